// File: rtl/pipeline_hazard.sv
// pipeline_hazard
// ---------------------------------------------------------------------------
// Decode-side hazard and bypass controller. Sits just upstream of the
// register-fetch/operand stage: it drives the register-file read addresses,
// decides each cycle whether the decoded instruction may issue, and
// registers the per-operand bypass selects, the immediate and the destination
// tag that the operand stage consumes during EXE. It tracks in-flight
// destination tags through EXE/MEM/WB and runs a HI/LO busy counter for the
// multiply/divide unit.
//
// Ports
//   clk, rst_n            clock (rising edge) / asynchronous active-low reset
//   ext_stall             downstream stall, freezes all pipeline tracking state
//   dec_valid             decode holds a valid instruction
//   dec_rs, dec_rt        source register indices
//   dec_use_rs/_rt        the operand is actually read
//   dec_use_imm           B operand is the sign-extended immediate
//   dec_imm               immediate field
//   dec_rd                destination index, 0 = no write
//   dec_is_load           instruction is a load
//   dec_is_mult/_div      instruction starts a multiply / divide
//   dec_reads_hilo        instruction reads HI or LO
//   rf_address_a/_b       register-file read addresses (= dec_rs / dec_rt)
//   rf_stall              ext_stall | hazard stall (combinational)
//   exe_valid             EXE holds a valid instruction
//   exe_a_bypass          0 = RF, 1 = mem_result, 2 = wb_result
//   exe_b_bypass          0 = RF, 1 = mem_result, 2 = wb_result, 3 = immediate
//   exe_instant_value     immediate carried into EXE
//   exe_rd/mem_rd/wb_rd   destination tags of the in-flight instructions
// ---------------------------------------------------------------------------
module pipeline_hazard #(
  parameter int unsigned MULT_CYCLES = 6,
  parameter int unsigned DIV_CYCLES  = 36
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ext_stall,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  input  logic        dec_use_rs,
  input  logic        dec_use_rt,
  input  logic        dec_use_imm,
  input  logic [15:0] dec_imm,
  input  logic [4:0]  dec_rd,
  input  logic        dec_is_load,
  input  logic        dec_is_mult,
  input  logic        dec_is_div,
  input  logic        dec_reads_hilo,
  output logic [4:0]  rf_address_a,
  output logic [4:0]  rf_address_b,
  output logic        rf_stall,
  output logic        exe_valid,
  output logic [1:0]  exe_a_bypass,
  output logic [2:0]  exe_b_bypass,
  output logic [15:0] exe_instant_value,
  output logic [4:0]  exe_rd,
  output logic [4:0]  mem_rd,
  output logic [4:0]  wb_rd
);

  // Bypass select encodings.
  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;  // producer currently in EXE -> MEM next cycle
  localparam logic [1:0] SEL_WB  = 2'd2;  // producer currently in MEM -> WB next cycle
  localparam logic [2:0] SEL_IMM = 3'd3;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES);

  // Outcome of resolving one source operand against the in-flight tags.
  typedef struct packed {
    logic       load_use;
    logic       collision;
    logic [1:0] sel;
  } src_res_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic        exe_valid_q, exe_valid_d;
  logic        exe_load_q,  exe_load_d;
  logic [1:0]  exe_a_bypass_q, exe_a_bypass_d;
  logic [2:0]  exe_b_bypass_q, exe_b_bypass_d;
  logic [15:0] exe_imm_q, exe_imm_d;
  logic [4:0]  exe_rd_q, exe_rd_d;
  logic [4:0]  mem_rd_q, mem_rd_d;
  logic [4:0]  wb_rd_q,  wb_rd_d;
  logic [5:0]  hl_cnt_q, hl_cnt_d;

  // ---------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------
  // Priority follows pipeline age: the youngest producer (EXE) wins. A match
  // against WB cannot be bypassed because the write lands on the same edge
  // as the read, so that case stalls one cycle and then reads the RF.
  function automatic src_res_t resolve(input logic       used,
                                       input logic [4:0] src,
                                       input logic [4:0] e_rd,
                                       input logic       e_load,
                                       input logic [4:0] m_rd,
                                       input logic [4:0] w_rd);
    src_res_t r;
    r = '0;
    if (used && (src != 5'd0)) begin
      if (src == e_rd) begin
        if (e_load) r.load_use = 1'b1;
        else        r.sel      = SEL_MEM;
      end else if (src == m_rd) begin
        r.sel = SEL_WB;
      end else if (src == w_rd) begin
        r.collision = 1'b1;
      end
    end
    return r;
  endfunction

  src_res_t res_a;
  src_res_t res_b;
  logic     hl_busy;
  logic     hz_stall;
  logic     advance;
  logic     issue;

  always_comb begin
    res_a = resolve(dec_valid & dec_use_rs, dec_rs,
                    exe_rd_q, exe_load_q, mem_rd_q, wb_rd_q);
    // With an immediate B operand, rt is not read and must not stall.
    res_b = resolve(dec_valid & dec_use_rt & ~dec_use_imm, dec_rt,
                    exe_rd_q, exe_load_q, mem_rd_q, wb_rd_q);

    hl_busy  = (dec_reads_hilo | dec_is_mult | dec_is_div) & (hl_cnt_q != 6'd0);
    hz_stall = dec_valid & (res_a.load_use  | res_b.load_use  |
                            res_a.collision | res_b.collision | hl_busy);

    advance = ~ext_stall;
    issue   = advance & ~hz_stall;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every signal driven here is given a default first so no path
  // leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    exe_valid_d    = exe_valid_q;
    exe_load_d     = exe_load_q;
    exe_a_bypass_d = exe_a_bypass_q;
    exe_b_bypass_d = exe_b_bypass_q;
    exe_imm_d      = exe_imm_q;
    exe_rd_d       = exe_rd_q;
    mem_rd_d       = mem_rd_q;
    wb_rd_d        = wb_rd_q;

    if (advance) begin
      // MEM and WB advance whether EXE takes the decode slot or a bubble.
      mem_rd_d = exe_rd_q;
      wb_rd_d  = mem_rd_q;

      if (issue) begin
        exe_valid_d    = dec_valid;
        exe_load_d     = dec_valid & dec_is_load;
        exe_rd_d       = dec_valid ? dec_rd : 5'd0;
        exe_a_bypass_d = res_a.sel;
        exe_b_bypass_d = (dec_valid && dec_use_imm) ? SEL_IMM : {1'b0, res_b.sel};
        exe_imm_d      = dec_imm;
      end else begin
        exe_valid_d    = 1'b0;
        exe_load_d     = 1'b0;
        exe_rd_d       = 5'd0;
        exe_a_bypass_d = SEL_RF;
        exe_b_bypass_d = 3'd0;
        exe_imm_d      = 16'd0;
      end
    end
  end

  // The HI/LO counter is not pipeline tracking state: it keeps counting
  // through both hazard and external stalls. It only loads on an edge where
  // the multiply/divide actually issues, which implies it is already zero.
  always_comb begin
    hl_cnt_d = hl_cnt_q;
    if (hl_cnt_q != 6'd0) hl_cnt_d = hl_cnt_q - 6'd1;
    if (issue && dec_valid) begin
      if (dec_is_div)       hl_cnt_d = DIV_LOAD;
      else if (dec_is_mult) hl_cnt_d = MULT_LOAD;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_valid_q    <= 1'b0;
      exe_load_q     <= 1'b0;
      exe_a_bypass_q <= SEL_RF;
      exe_b_bypass_q <= 3'd0;
      exe_imm_q      <= 16'd0;
      exe_rd_q       <= 5'd0;
      mem_rd_q       <= 5'd0;
      wb_rd_q        <= 5'd0;
      hl_cnt_q       <= 6'd0;
    end else begin
      exe_valid_q    <= exe_valid_d;
      exe_load_q     <= exe_load_d;
      exe_a_bypass_q <= exe_a_bypass_d;
      exe_b_bypass_q <= exe_b_bypass_d;
      exe_imm_q      <= exe_imm_d;
      exe_rd_q       <= exe_rd_d;
      mem_rd_q       <= mem_rd_d;
      wb_rd_q        <= wb_rd_d;
      hl_cnt_q       <= hl_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign rf_address_a      = dec_rs;
  assign rf_address_b      = dec_rt;
  assign rf_stall          = ext_stall | hz_stall;
  assign exe_valid         = exe_valid_q;
  assign exe_a_bypass      = exe_a_bypass_q;
  assign exe_b_bypass      = exe_b_bypass_q;
  assign exe_instant_value = exe_imm_q;
  assign exe_rd            = exe_rd_q;
  assign mem_rd            = mem_rd_q;
  assign wb_rd             = wb_rd_q;

endmodule
